gpio_port_ctrl: RTL

- Bus-side controller for the `bidir_io` pad block.
- Holds the output-data and direction registers that drive `out_data` and `out_ena`.
- Synchronises and debounces the pad block's `gpio_in_data`.
- Latches per-bit edges with write-1-to-clear flags and raises a maskable interrupt.
- Sits between the 32-bit host register bus and one `bidir_io` instance of matching width.

---
 rtl/gpio_port_ctrl.sv | 176 +++++++++++++++++
 1 files changed

// File: rtl/gpio_port_ctrl.sv
// gpio_port_ctrl: 32-bit host register front end for one bidir_io pad block.
// Holds OUT/DDR, synchronises and debounces pad inputs, latches W1C edge flags, drives a maskable irq.
module gpio_port_ctrl #(
    parameter int IOWidth       = 36,
    parameter int DebounceWidth = 8
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [3:0]         addr,
    input  logic               wr_strobe,
    input  logic               rd_strobe,
    input  logic [31:0]        data_in,
    output logic [31:0]        data_out,
    output logic               rd_valid,
    output logic [IOWidth-1:0] out_data,
    output logic [IOWidth-1:0] out_ena,
    input  logic [IOWidth-1:0] gpio_in_data,
    output logic               irq
);

    localparam int HiW = IOWidth - 32;

    localparam logic [3:0] A_OUT_LO   = 4'd0;
    localparam logic [3:0] A_OUT_HI   = 4'd1;
    localparam logic [3:0] A_DDR_LO   = 4'd2;
    localparam logic [3:0] A_DDR_HI   = 4'd3;
    localparam logic [3:0] A_IN_LO    = 4'd4;
    localparam logic [3:0] A_IN_HI    = 4'd5;
    localparam logic [3:0] A_EDGE_LO  = 4'd6;
    localparam logic [3:0] A_EDGE_HI  = 4'd7;
    localparam logic [3:0] A_IRQEN_LO = 4'd8;
    localparam logic [3:0] A_IRQEN_HI = 4'd9;
    localparam logic [3:0] A_CFG      = 4'd10;

    logic [IOWidth-1:0]       sync_r;
    logic [IOWidth-1:0]       deb_r;
    logic [IOWidth-1:0]       edge_r;
    logic [IOWidth-1:0]       irqen_r;
    logic [DebounceWidth-1:0] cnt_r [IOWidth];
    logic [DebounceWidth-1:0] filt_r;
    logic                     rise_en_r;
    logic                     fall_en_r;

    logic [IOWidth-1:0]       deb_nxt_s;
    logic [IOWidth-1:0]       rise_s;
    logic [IOWidth-1:0]       fall_s;
    logic [IOWidth-1:0]       edge_set_s;
    logic [IOWidth-1:0]       edge_clr_s;
    logic [DebounceWidth-1:0] cnt_nxt_s [IOWidth];
    logic [31:0]              rd_data_s;

    function automatic logic [31:0] hi_word(input logic [IOWidth-1:0] v);
        return 32'(v[IOWidth-1:32]);
    endfunction

    // Per-bit debounce: count consecutive mismatch cycles, adopt sync once the count reaches filt
    always_comb begin
        deb_nxt_s = deb_r;
        rise_s    = '0;
        fall_s    = '0;
        for (int i = 0; i < IOWidth; i++) begin
            cnt_nxt_s[i] = cnt_r[i];
            if (sync_r[i] == deb_r[i]) begin
                cnt_nxt_s[i] = '0;
            end else if (cnt_r[i] >= filt_r) begin
                deb_nxt_s[i] = sync_r[i];
                cnt_nxt_s[i] = '0;
                if (sync_r[i]) begin
                    rise_s[i] = 1'b1;
                end else begin
                    fall_s[i] = 1'b1;
                end
            end else if (cnt_r[i] != {DebounceWidth{1'b1}}) begin
                cnt_nxt_s[i] = cnt_r[i] + DebounceWidth'(1'b1);
            end else begin
                cnt_nxt_s[i] = cnt_r[i];
            end
        end
    end

    assign edge_set_s = (rise_s & {IOWidth{rise_en_r}}) | (fall_s & {IOWidth{fall_en_r}});

    // Write-1-to-clear mask from host writes to the EDGE words
    always_comb begin
        edge_clr_s = '0;
        if (wr_strobe && (addr == A_EDGE_LO)) begin
            edge_clr_s[31:0] = data_in;
        end else if (wr_strobe && (addr == A_EDGE_HI)) begin
            edge_clr_s[IOWidth-1:32] = data_in[HiW-1:0];
        end else begin
            edge_clr_s = '0;
        end
    end

    // Read mux over current register contents, so a same-cycle write is not yet visible
    always_comb begin
        rd_data_s = 32'd0;
        case (addr)
            A_OUT_LO:   rd_data_s = out_data[31:0];
            A_OUT_HI:   rd_data_s = hi_word(out_data);
            A_DDR_LO:   rd_data_s = out_ena[31:0];
            A_DDR_HI:   rd_data_s = hi_word(out_ena);
            A_IN_LO:    rd_data_s = deb_r[31:0];
            A_IN_HI:    rd_data_s = hi_word(deb_r);
            A_EDGE_LO:  rd_data_s = edge_r[31:0];
            A_EDGE_HI:  rd_data_s = hi_word(edge_r);
            A_IRQEN_LO: rd_data_s = irqen_r[31:0];
            A_IRQEN_HI: rd_data_s = hi_word(irqen_r);
            A_CFG: begin
                rd_data_s     = 32'(filt_r);
                rd_data_s[16] = rise_en_r;
                rd_data_s[17] = fall_en_r;
            end
            default:    rd_data_s = 32'd0;
        endcase
    end

    // Input synchroniser, debounce state, edge flags (set beats clear) and registered irq
    always_ff @(posedge clk) begin
        if (reset) begin
            sync_r <= '0;
            deb_r  <= '0;
            edge_r <= '0;
            irq    <= 1'b0;
            for (int i = 0; i < IOWidth; i++) begin
                cnt_r[i] <= '0;
            end
        end else begin
            sync_r <= gpio_in_data;
            deb_r  <= deb_nxt_s;
            edge_r <= (edge_r & ~edge_clr_s) | edge_set_s;
            irq    <= |(edge_r & irqen_r);
            for (int i = 0; i < IOWidth; i++) begin
                cnt_r[i] <= cnt_nxt_s[i];
            end
        end
    end

    // Host-writable registers and the registered read return
    always_ff @(posedge clk) begin
        if (reset) begin
            out_data  <= '0;
            out_ena   <= '0;
            irqen_r   <= '0;
            filt_r    <= '0;
            rise_en_r <= 1'b0;
            fall_en_r <= 1'b0;
            data_out  <= 32'd0;
            rd_valid  <= 1'b0;
        end else begin
            rd_valid <= rd_strobe;
            if (rd_strobe) begin
                data_out <= rd_data_s;
            end else begin
                data_out <= data_out;
            end
            if (wr_strobe) begin
                case (addr)
                    A_OUT_LO:   out_data[31:0]         <= data_in;
                    A_OUT_HI:   out_data[IOWidth-1:32] <= data_in[HiW-1:0];
                    A_DDR_LO:   out_ena[31:0]          <= data_in;
                    A_DDR_HI:   out_ena[IOWidth-1:32]  <= data_in[HiW-1:0];
                    A_IRQEN_LO: irqen_r[31:0]          <= data_in;
                    A_IRQEN_HI: irqen_r[IOWidth-1:32]  <= data_in[HiW-1:0];
                    A_CFG: begin
                        filt_r    <= data_in[DebounceWidth-1:0];
                        rise_en_r <= data_in[16];
                        fall_en_r <= data_in[17];
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule
